pc_fetch_ctrl: RTL and testbench

- Sequences the program counter through a multi-cycle fetch/resolve loop.
- Issues instruction-memory requests and hands fetched instructions to decode with a valid/ready handshake.
- Computes the next PC from decode's resolution:
  - sequential: PC+4
  - PC-relative branch: PC+4+(imm<<2)
  - register jump: gated by a zero/condition flag
- Sits between the instruction memory and the decode/execute stage; owns the architectural PC register.

---
 rtl/pc_ctrl_pkg.sv | 20 ++
 rtl/pc_fetch_ctrl_if.sv | 30 +++
 rtl/pc_next_calc.sv | 33 +++
 rtl/pc_fetch_ctrl.sv | 123 ++++++++++++
 tb/tb_pc_fetch_ctrl.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/pc_ctrl_pkg.sv
// Shared types for the PC fetch controller: FSM states, resolve kinds, PC step.
package pc_ctrl_pkg;

    typedef enum logic [1:0] {
        FETCH,
        HANDOFF,
        RESOLVE,
        HALTED
    } state_t;

    typedef enum logic [1:0] {
        KIND_SEQ     = 2'b00,
        KIND_BRANCH  = 2'b01,
        KIND_JUMPREG = 2'b10,
        KIND_HALT    = 2'b11
    } kind_t;

    localparam logic [31:0] PC_STEP = 32'd4;

endpackage

// File: rtl/pc_fetch_ctrl_if.sv
// Instruction-memory and decode handshake bundle; master is the fetch controller.
interface pc_fetch_ctrl_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;
    logic        res_valid;
    logic [1:0]  res_kind;
    logic        res_zero;
    logic [31:0] res_imm;
    logic [31:0] res_target;

    modport master (
        output imem_req, imem_addr, instr_valid, instr, instr_pc,
        input  imem_ack, imem_rdata, instr_ready,
        input  res_valid, res_kind, res_zero, res_imm, res_target
    );

    modport slave (
        input  imem_req, imem_addr, instr_valid, instr, instr_pc,
        output imem_ack, imem_rdata, instr_ready,
        output res_valid, res_kind, res_zero, res_imm, res_target
    );

endinterface

// File: rtl/pc_next_calc.sv
// Combinational next-PC selection from decode's resolution of the current instruction.
module pc_next_calc
    import pc_ctrl_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [1:0]  res_kind,
    input  logic        res_zero,
    input  logic [31:0] res_imm,
    input  logic [31:0] res_target,
    output logic [31:0] next_pc,
    output logic        misaligned
);

    logic [31:0] seq_pc;
    logic [31:0] br_pc;

    assign seq_pc = pc + PC_STEP;
    // Word offset: the shift drops the immediate's top two bits.
    assign br_pc  = seq_pc + (res_imm << 2);

    always_comb begin
        next_pc = seq_pc;
        unique case (1'b1)
            res_kind == KIND_SEQ:     next_pc = seq_pc;
            res_kind == KIND_BRANCH:  next_pc = res_zero ? br_pc : seq_pc;
            res_kind == KIND_JUMPREG: next_pc = res_zero ? res_target : seq_pc;
            res_kind == KIND_HALT:    next_pc = pc;
        endcase
    end

    assign misaligned = |next_pc[1:0];

endmodule

// File: rtl/pc_fetch_ctrl.sv
// PC fetch/resolve controller owning the architectural PC.
// Define PC_ALIGN_CHECK_EN to add align_fault and halt on misaligned targets.
module pc_fetch_ctrl
    import pc_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          MAX_WAIT = 16
) (
    input  logic           clk,
    input  logic           rst,
    pc_fetch_ctrl_if.master bus,
    output logic [31:0]    pc,
    output logic           halted,
    output logic           timeout
`ifdef PC_ALIGN_CHECK_EN
    ,
    output logic           align_fault
`endif
);

    localparam int CW = $clog2(MAX_WAIT) + 1;
    localparam logic [CW-1:0] WMAX  = CW'(MAX_WAIT);
    localparam logic [CW-1:0] WLAST = CW'(MAX_WAIT - 1);

`ifdef PC_ALIGN_CHECK_EN
    localparam bit ALIGN_EN = 1'b1;
`else
    localparam bit ALIGN_EN = 1'b0;
`endif

    state_t        state;
    state_t        state_d;
    logic          cap;
    logic          adv;
    logic          fault;
    logic [31:0]   next_pc;
    logic          misaligned;
    logic [31:0]   instr_q;
    logic [31:0]   ipc_q;
    logic [CW-1:0] wait_cnt;

    pc_next_calc u_calc (
        .pc         (pc),
        .res_kind   (bus.res_kind),
        .res_zero   (bus.res_zero),
        .res_imm    (bus.res_imm),
        .res_target (bus.res_target),
        .next_pc    (next_pc),
        .misaligned (misaligned)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= FETCH;
        else     state <= state_d;
    end

    always_comb begin
        state_d = state;
        cap     = 1'b0;
        adv     = 1'b0;
        fault   = 1'b0;
        unique case (state)
            FETCH: begin
                if (bus.imem_ack) begin
                    cap     = 1'b1;
                    state_d = HANDOFF;
                end
            end
            HANDOFF: begin
                if (bus.instr_ready) state_d = RESOLVE;
            end
            RESOLVE: begin
                if (bus.res_valid) begin
                    fault = ALIGN_EN && misaligned &&
                            (bus.res_kind != KIND_HALT);
                    if (bus.res_kind == KIND_HALT || fault) begin
                        state_d = HALTED;
                    end else begin
                        adv     = 1'b1;
                        state_d = FETCH;
                    end
                end
            end
            HALTED: state_d = HALTED;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc       <= RESET_PC;
            instr_q  <= '0;
            ipc_q    <= '0;
            wait_cnt <= '0;
            timeout  <= 1'b0;
        end else begin
            if (cap) begin
                instr_q  <= bus.imem_rdata;
                ipc_q    <= pc;
                wait_cnt <= '0;
            end else if (state == FETCH) begin
                if (wait_cnt != WMAX) wait_cnt <= wait_cnt + 1'b1;
                if (wait_cnt >= WLAST) timeout <= 1'b1;
            end
            if (adv) pc <= next_pc;
        end
    end

`ifdef PC_ALIGN_CHECK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)        align_fault <= 1'b0;
        else if (fault) align_fault <= 1'b1;
    end
`endif

    // rst gates the request so it is low for the whole reset interval.
    assign bus.imem_req    = (state == FETCH) && !rst;
    assign bus.imem_addr   = pc;
    assign bus.instr_valid = (state == HANDOFF);
    assign bus.instr       = instr_q;
    assign bus.instr_pc    = ipc_q;
    assign halted          = (state == HALTED);

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Self-checking bench for pc_fetch_ctrl: vector table, random run, corner sequences.
module tb_pc_fetch_ctrl;
    import pc_ctrl_pkg::*;

    localparam logic [31:0] RPC = 32'h0000_0000;
    localparam int          MW  = 16;

    typedef struct {
        logic [1:0]  k;
        logic        z;
        logic [31:0] imm;
        logic [31:0] tgt;
        int          ackd;
        int          rdyd;
        int          resd;
        logic [31:0] exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc;
    logic        halted;
    logic        timeout;
`ifdef PC_ALIGN_CHECK_EN
    logic        align_fault;
`endif

    int          checks = 0;
    int          errors = 0;
    logic [31:0] mp;
    vec_t        tbl[10];

    pc_fetch_ctrl_if bus();

    pc_fetch_ctrl #(.RESET_PC(RPC), .MAX_WAIT(MW)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .pc          (pc),
        .halted      (halted),
        .timeout     (timeout)
`ifdef PC_ALIGN_CHECK_EN
        ,
        .align_fault (align_fault)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] model_next(
        input logic [31:0] p, input logic [1:0] k, input logic z,
        input logic [31:0] imm, input logic [31:0] tgt);
        case (k)
            2'd0:    return p + 32'd4;
            2'd1:    return z ? p + 32'd4 + imm * 32'd4 : p + 32'd4;
            2'd2:    return z ? tgt : p + 32'd4;
            default: return p;
        endcase
    endfunction

    task automatic idle();
        bus.imem_ack    = 1'b0;
        bus.imem_rdata  = '0;
        bus.instr_ready = 1'b0;
        bus.res_valid   = 1'b0;
        bus.res_kind    = 2'd0;
        bus.res_zero    = 1'b0;
        bus.res_imm     = '0;
        bus.res_target  = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle();
        @(negedge clk);
        chk("rst_req", bus.imem_req, 1'b0);
        chk("rst_pc", pc, RPC);
        chk("rst_vld", bus.instr_valid, 1'b0);
        chk("rst_instr", bus.instr, 32'd0);
        chk("rst_ipc", bus.instr_pc, 32'd0);
        chk("rst_halt", halted, 1'b0);
        chk("rst_tmo", timeout, 1'b0);
`ifdef PC_ALIGN_CHECK_EN
        chk("rst_afault", align_fault, 1'b0);
`endif
        rst = 1'b0;
        mp  = RPC;
        #1;
        chk("boot_req", bus.imem_req, 1'b1);
        chk("boot_addr", bus.imem_addr, RPC);
    endtask

    task automatic run_instr(input logic [1:0] k, input logic z,
                             input logic [31:0] imm, input logic [31:0] tgt,
                             input int ackd, input int rdyd, input int resd,
                             output logic [31:0] got);
        logic [31:0] rd;
        logic [31:0] exp;
        logic        hx;
        rd = $urandom | 32'h1;
        chk("req", bus.imem_req, 1'b1);
        chk("addr", bus.imem_addr, mp);
        repeat (ackd) begin
            bus.imem_ack = 1'b0;
            @(negedge clk);
            chk("req_hold", bus.imem_req, 1'b1);
            chk("addr_hold", bus.imem_addr, mp);
            chk("vld_early", bus.instr_valid, 1'b0);
        end
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = rd;
        @(negedge clk);
        bus.imem_ack = 1'b0;
        chk("vld", bus.instr_valid, 1'b1);
        chk("instr", bus.instr, rd);
        chk("ipc", bus.instr_pc, mp);
        chk("req_drop", bus.imem_req, 1'b0);
        repeat (rdyd) begin
            bus.instr_ready = 1'b0;
            bus.res_valid   = 1'b1;
            bus.res_kind    = KIND_HALT;
            bus.imem_ack    = 1'b1;
            bus.imem_rdata  = ~rd;
            @(negedge clk);
            chk("vld_hold", bus.instr_valid, 1'b1);
            chk("instr_hold", bus.instr, rd);
            chk("pc_hold", pc, mp);
            chk("stray_res", halted, 1'b0);
        end
        bus.res_valid   = 1'b0;
        bus.imem_ack    = 1'b0;
        bus.instr_ready = 1'b1;
        @(negedge clk);
        bus.instr_ready = 1'b0;
        chk("vld_drop", bus.instr_valid, 1'b0);
        repeat (resd) begin
            @(negedge clk);
            chk("res_wait_pc", pc, mp);
            chk("res_wait_req", bus.imem_req, 1'b0);
        end
        bus.res_valid  = 1'b1;
        bus.res_kind   = k;
        bus.res_zero   = z;
        bus.res_imm    = imm;
        bus.res_target = tgt;
        @(negedge clk);
        bus.res_valid = 1'b0;
        got = pc;
        exp = model_next(mp, k, z, imm, tgt);
        hx  = (k == 2'd3);
`ifdef PC_ALIGN_CHECK_EN
        if (exp[1:0] != 2'b00) begin
            hx  = 1'b1;
            exp = mp;
        end
`endif
        mp = exp;
        chk("pc_next", pc, mp);
        chk("halted", halted, hx);
        chk("tmo0", timeout, 1'b0);
        if (hx) chk("req_halt", bus.imem_req, 1'b0);
        else    chk("addr_next", bus.imem_addr, mp);
    endtask

    initial begin
        logic [31:0] got;
        tbl[0] = '{2'd0, 1'b0, 32'd0,          32'd0,          0, 0, 0, 32'd4};
        tbl[1] = '{2'd0, 1'b0, 32'd0,          32'd0,          3, 2, 0, 32'd8};
        tbl[2] = '{2'd1, 1'b1, 32'd5,          32'd0,          0, 0, 0, 32'd32};
        tbl[3] = '{2'd1, 1'b0, 32'd5,          32'd0,          1, 0, 1, 32'd36};
        tbl[4] = '{2'd2, 1'b1, 32'd0,          32'd32,         0, 1, 0, 32'd32};
        tbl[5] = '{2'd2, 1'b0, 32'd0,          32'h100,        0, 0, 0, 32'd36};
        tbl[6] = '{2'd1, 1'b1, 32'hFFFF_FFFD,  32'd0,          2, 0, 2, 32'd28};
        tbl[7] = '{2'd2, 1'b1, 32'd0,          32'hFFFF_FFFC,  0, 0, 0, 32'hFFFF_FFFC};
        tbl[8] = '{2'd0, 1'b0, 32'd0,          32'd0,          0, 0, 0, 32'd0};
        tbl[9] = '{2'd1, 1'b1, 32'h4000_0001,  32'd0,          0, 0, 0, 32'd8};

        do_reset();
        for (int i = 0; i < 10; i++) begin
            run_instr(tbl[i].k, tbl[i].z, tbl[i].imm, tbl[i].tgt,
                      tbl[i].ackd, tbl[i].rdyd, tbl[i].resd, got);
            chk("tbl_pc", got, tbl[i].exp);
        end

        for (int i = 0; i < 40; i++) begin
            run_instr(2'($urandom_range(0, 2)), 1'($urandom_range(0, 1)),
                      $urandom, $urandom & 32'hFFFF_FFFC,
                      $urandom_range(0, 3), $urandom_range(0, 2),
                      $urandom_range(0, 2), got);
        end

        run_instr(2'd3, 1'b0, 32'd0, 32'd0, 0, 0, 0, got);
        repeat (3) begin
            bus.imem_ack  = 1'b1;
            bus.res_valid = 1'b1;
            bus.res_kind  = KIND_SEQ;
            @(negedge clk);
            chk("halt_noreq", bus.imem_req, 1'b0);
            chk("halt_stay", halted, 1'b1);
            chk("halt_pc", pc, mp);
        end

        do_reset();
        run_instr(2'd2, 1'b1, 32'd0, 32'd34, 0, 0, 0, got);
`ifdef PC_ALIGN_CHECK_EN
        chk("afault", align_fault, 1'b1);
        chk("afault_pc", got, RPC);
`else
        chk("misalign_pc", got, 32'd34);
`endif

        do_reset();
        run_instr(2'd0, 1'b0, 32'd0, 32'd0, 0, 0, 0, got);
        bus.imem_ack = 1'b0;
        repeat (MW - 1) @(negedge clk);
        chk("tmo_early", timeout, 1'b0);
        chk("tmo_req", bus.imem_req, 1'b1);
        @(negedge clk);
        chk("tmo_set", timeout, 1'b1);
        repeat (3) @(negedge clk);
        chk("tmo_sticky", timeout, 1'b1);
        chk("tmo_addr", bus.imem_addr, 32'd4);
        #2 rst = 1'b1;
        #1;
        chk("mid_req", bus.imem_req, 1'b0);
        chk("mid_pc", pc, RPC);
        chk("mid_tmo", timeout, 1'b0);
        chk("mid_instr", bus.instr, 32'd0);
        chk("mid_vld", bus.instr_valid, 1'b0);
        chk("mid_halt", halted, 1'b0);
        do_reset();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
